div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter.sv | 122 ++++++++++++
 tb/tb_div_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// Round-robin arbiter that shares one sign-magnitude Q15 divider among NREQ requesters.
// Divide-by-zero is answered locally with a saturated result; other results pass through unmodified.
module div_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 27
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*W-1:0] i_dividend,
  input  logic [NREQ*W-1:0] i_divisor,
  output logic [NREQ-1:0]   o_ack,
  output logic [NREQ-1:0]   o_valid,
  output logic [W-1:0]      o_quotient,
  output logic              o_overflow,
  output logic              o_busy,
  output logic [W-1:0]      o_div_dividend,
  output logic [W-1:0]      o_div_divisor,
  output logic              o_div_start,
  input  logic [W-1:0]      i_div_quotient,
  input  logic              i_div_complete,
  input  logic              i_div_overflow
);
  localparam int LG = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, DZERO, START, WAIT_LOW, WAIT_HIGH, RESP} state_t;

  state_t        state, state_nxt;
  logic [LG-1:0] last_grant, tag, win, cand;
  logic          found, grant, dz;
  logic [W-1:0]  win_dvd, win_dvs;

  function automatic logic [W-1:0] sat_dzero(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    return {dvd[W-1] ^ dvs[W-1], {(W-1){1'b1}}};
  endfunction

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = LG'((int'(last_grant) + i) % NREQ);
      if (!found && i_req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    win_dvd = '0;
    win_dvs = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win == LG'(k)) begin
        win_dvd = i_dividend[k*W +: W];
        win_dvs = i_divisor[k*W +: W];
      end
    end
  end

  assign dz    = ~|win_dvs[W-2:0];
  // The divider cannot be reset, so a grant also waits for it to report idle.
  assign grant = (state == IDLE) && !i_rst && found && i_div_complete;

  always_comb begin
    state_nxt   = state;
    o_ack       = '0;
    o_valid     = '0;
    o_div_start = 1'b0;
    o_busy      = (state != IDLE) && !i_rst;
    unique case (state)
      IDLE: begin
        if (grant) begin
          o_ack     = NREQ'(1) << win;
          state_nxt = dz ? DZERO : START;
        end
      end
      DZERO:     state_nxt = RESP;
      START: begin
        o_div_start = !i_rst;
        state_nxt   = WAIT_LOW;
      end
      WAIT_LOW:  if (!i_div_complete) state_nxt = WAIT_HIGH;
      WAIT_HIGH: if (i_div_complete) state_nxt = RESP;
      RESP: begin
        o_valid   = i_rst ? '0 : (NREQ'(1) << tag);
        state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      last_grant <= LG'(NREQ - 1);
      o_quotient <= '0;
      o_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) last_grant <= win;
      if (state == DZERO) begin
        o_quotient <= sat_dzero(o_div_dividend, o_div_divisor);
        o_overflow <= 1'b1;
      end else if (state == WAIT_HIGH && i_div_complete) begin
        o_quotient <= i_div_quotient;
        o_overflow <= i_div_overflow;
      end
    end
  end

  // Operand and tag capture at the grant edge
  always_ff @(posedge i_clk) begin
    if (grant) begin
      tag            <= win;
      o_div_dividend <= win_dvd;
      o_div_divisor  <= win_dvs;
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural non-resettable divider and an ack/valid scoreboard.
module tb_div_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 27;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [NREQ-1:0]   i_req = '0;
  logic [NREQ*W-1:0] i_dividend = '0;
  logic [NREQ*W-1:0] i_divisor = '0;
  logic [NREQ-1:0]   o_ack, o_valid;
  logic [W-1:0]      o_quotient, o_div_dividend, o_div_divisor;
  logic              o_overflow, o_busy, o_div_start;
  logic [W-1:0]      i_div_quotient = '0;
  logic              i_div_complete = 1'b1;
  logic              i_div_overflow = 1'b0;

  typedef struct {
    logic [NREQ-1:0] oh;
    logic [W-1:0]    q;
    logic            ovf;
    int              ack_cyc;
    bit              dz;
  } exp_t;

  exp_t sb[$];
  int   ack_log[$];
  int   val_log[$];
  int   errors = 0, checks = 0, cyc = 0;
  int   n_ack = 0, n_valid = 0, n_start = 0, last_ack_cyc = 0, rise_cyc = 0;
  int   div_lat = 4, div_cnt = 0;
  logic [W:0] div_pend = '0;

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  div_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req),
    .i_dividend(i_dividend), .i_divisor(i_divisor),
    .o_ack(o_ack), .o_valid(o_valid), .o_quotient(o_quotient), .o_overflow(o_overflow),
    .o_busy(o_busy), .o_div_dividend(o_div_dividend), .o_div_divisor(o_div_divisor),
    .o_div_start(o_div_start), .i_div_quotient(i_div_quotient),
    .i_div_complete(i_div_complete), .i_div_overflow(i_div_overflow)
  );

  // Sign-magnitude Q15 divide: returns {overflow, quotient}; zero divisor or too-large result saturates.
  function automatic logic [W:0] div_model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic              s;
    longint unsigned   num, mag;
    s = a[W-1] ^ b[W-1];
    if (b[W-2:0] == '0) return {1'b1, s, {(W-1){1'b1}}};
    num = 64'(a[W-2:0]) << 15;
    mag = num / 64'(b[W-2:0]);
    if (mag >= (64'd1 << (W-1))) return {1'b1, s, {(W-1){1'b1}}};
    return {1'b0, s, mag[W-2:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    i_dividend[k*W +: W] = a;
    i_divisor[k*W +: W]  = b;
  endtask

  task automatic wait_ack(input int target);
    for (int t = 0; t < 400 && n_ack < target; t++) tick();
    check("ack_count", n_ack, target);
  endtask

  task automatic wait_valid(input int target);
    for (int t = 0; t < 400 && n_valid < target; t++) tick();
    check("valid_count", n_valid, target);
  endtask

  task automatic do_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input int starts);
    int s0, a0, v0;
    set_ops(k, a, b);
    s0 = n_start;
    a0 = n_ack;
    v0 = n_valid;
    i_req[k] = 1'b1;
    wait_ack(a0 + 1);
    i_req[k] = 1'b0;
    if (ack_log.size() > 0) check("ack_requester", ack_log[$], k);
    wait_valid(v0 + 1);
    check("start_pulses", n_start - s0, starts);
  endtask

  // Non-resettable divider: drops complete on start, raises it div_lat cycles later
  always @(posedge i_clk) begin
    #1;
    if (o_div_start === 1'b1) begin
      i_div_complete = 1'b0;
      div_cnt        = div_lat;
      div_pend       = div_model(o_div_dividend, o_div_divisor);
    end else if (div_cnt > 0) begin
      div_cnt--;
      if (div_cnt == 0) begin
        i_div_complete = 1'b1;
        i_div_quotient = div_pend[W-1:0];
        i_div_overflow = div_pend[W];
        rise_cyc       = cyc;
      end
    end
  end

  // Scoreboard: push on ack, pop and compare on valid
  always @(negedge i_clk) begin
    exp_t e;
    int   k;
    if (o_div_start === 1'b1) n_start++;
    if (|o_ack) begin
      k = 0;
      for (int j = 0; j < NREQ; j++) if (o_ack[j]) k = j;
      e.oh = NREQ'(1) << k;
      {e.ovf, e.q} = div_model(i_dividend[k*W +: W], i_divisor[k*W +: W]);
      e.dz = (i_divisor[k*W +: W-1] == '0);
      e.ack_cyc = cyc;
      sb.push_back(e);
      n_ack++;
      ack_log.push_back(k);
      last_ack_cyc = cyc;
      check("ack_onehot", $countones(o_ack), 1);
    end
    if (|o_valid) begin
      k = 0;
      for (int j = 0; j < NREQ; j++) if (o_valid[j]) k = j;
      n_valid++;
      val_log.push_back(k);
      check("ack_valid_excl", o_ack, 0);
      if (sb.size() == 0) begin
        check("valid_unexpected", o_valid, 0);
      end else begin
        e = sb.pop_front();
        check("valid_tag", o_valid, e.oh);
        check("quotient", o_quotient, e.q);
        check("overflow", o_overflow, e.ovf);
        if (e.dz) check("dz_latency", cyc, e.ack_cyc + 2);
        else      check("div_latency", cyc, rise_cyc + 1);
      end
    end
  end

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int a0, v0, s0;

    // Reset with all four requesters already asserted
    set_ops(0, 27'h000C000, 27'h0004000);
    set_ops(1, 27'h0008000, 27'h0010000);
    set_ops(2, 27'h4010000, 27'h0008000);
    set_ops(3, 27'h0006000, 27'h4003000);
    i_req = 4'hF;
    tick();
    tick();
    check("rst_ack", o_ack, 0);
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_start", o_div_start, 0);
    check("rst_quotient", o_quotient, 0);
    check("rst_overflow", o_overflow, 0);
    i_rst = 1'b0;

    wait_ack(5);
    i_req = '0;
    wait_valid(5);
    for (int i = 0; i < 5; i++) begin
      if (i < ack_log.size()) check("grant_order", ack_log[i], exp_order[i]);
      if (i < val_log.size()) check("valid_order", val_log[i], exp_order[i]);
    end

    do_op(0, 27'h000C000, 27'h0004000, 1);
    check("pos_quotient", o_quotient, 27'h0018000);
    check("pos_overflow", o_overflow, 0);

    do_op(2, 27'h400C000, 27'h0004000, 1);
    check("neg_quotient", o_quotient, 27'h4018000);
    check("neg_overflow", o_overflow, 0);

    do_op(1, 27'h0008000, 27'h4000000, 0);
    check("dz_quotient", o_quotient, 27'h7FFFFFF);
    check("dz_overflow", o_overflow, 1);

    do_op(3, 27'h3FFFFFF, 27'h0000001, 1);
    check("divovf_overflow", o_overflow, 1);

    // Reset while the divider is busy, request kept high throughout
    set_ops(0, 27'h000C000, 27'h0004000);
    div_lat = 20;
    a0 = n_ack;
    v0 = n_valid;
    s0 = n_start;
    i_req[0] = 1'b1;
    for (int t = 0; t < 100 && n_start == s0; t++) tick();
    check("abort_started", n_start, s0 + 1);
    repeat (9) tick();
    i_rst = 1'b1;
    sb.delete();
    tick();
    i_rst = 1'b0;
    div_lat = 4;
    check("abort_rst_busy", o_busy, 0);
    wait_ack(a0 + 2);
    check("regrant_cycle", last_ack_cyc, rise_cyc);
    check("abort_no_valid", n_valid, v0);
    i_req[0] = 1'b0;
    wait_valid(v0 + 1);
    check("abort_rerun_quotient", o_quotient, 27'h0018000);

    // Requester 3 raises and withdraws its request while another op is in flight
    set_ops(1, 27'h0008000, 27'h0010000);
    set_ops(3, 27'h0004000, 27'h0008000);
    div_lat = 8;
    a0 = n_ack;
    v0 = n_valid;
    i_req[1] = 1'b1;
    wait_ack(a0 + 1);
    i_req[1] = 1'b0;
    tick();
    i_req[3] = 1'b1;
    tick();
    tick();
    i_req[3] = 1'b0;
    wait_valid(v0 + 1);
    repeat (5) tick();
    check("withdrawn_no_ack", n_ack, a0 + 1);
    check("withdrawn_idle", o_busy, 0);
    check("withdrawn_quotient", o_quotient, 27'h0004000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
